// File: rtl/alu_ex_wb_stage.sv
// EX/WB stage: 2-entry skid buffer, in-order flag commit, forwarding port.
// Optional sticky overflow enabled by ALU_EX_WB_STICKY_OV_EN.
module alu_ex_wb_stage #(
  parameter int LENGTH = 128,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] in_result,
  input  logic              in_carry,
  input  logic              in_zero,
  input  logic              in_sign,
  input  logic              in_overflow,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wen,
  input  logic              in_fwen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wen,
  output logic [3:0]        status,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [LENGTH-1:0] fwd_data,
  input  logic              ov_clr,
  output logic              ov_sticky
);

  typedef struct packed {
    logic [LENGTH-1:0] res;
    logic              c;
    logic              z;
    logic              s;
    logic              v;
    logic [RD_W-1:0]   rd;
    logic              wen;
    logic              fwen;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  ent_t       main_q, main_d;
  ent_t       skid_q, skid_d;
  ent_t       in_ent;
  logic       in_ready_q, in_ready_d;
  logic [3:0] status_q, status_d;
  logic       main_vld, skid_vld;
  logic       acc, take;
  logic       main_hit, skid_hit;

  assign in_ent = '{res: in_result, c: in_carry, z: in_zero,
                    s: in_sign, v: in_overflow, rd: in_rd,
                    wen: in_wen, fwen: in_fwen};

  assign acc  = in_valid & in_ready_q & ~flush;
  assign take = main_vld & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (acc) state_d = ONE;
        ONE: begin
          if (acc && !take)      state_d = FULL;
          else if (!acc && take) state_d = EMPTY;
        end
        FULL: if (take) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    main_vld = (state_q == ONE) || (state_q == FULL);
    skid_vld = (state_q == FULL);
  end

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (state_q == EMPTY) begin
      if (acc) main_d = in_ent;
    end else if (state_q == ONE) begin
      if (acc && take) main_d = in_ent;
      else if (acc)    skid_d = in_ent;
    end else if (state_q == FULL) begin
      if (take) main_d = skid_q;
    end
  end

  // Flags commit on the take, even when a flush lands in the same cycle
  always_comb begin
    status_d = status_q;
    if (take && main_q.fwen)
      status_d = {main_q.c, main_q.z, main_q.s, main_q.v};
  end

  assign in_ready_d = (state_d != FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      status_q   <= '0;
      in_ready_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      status_q   <= status_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign status     = status_q;
  assign out_valid  = main_vld;
  assign out_result = main_vld ? main_q.res : '0;
  assign out_rd     = main_vld ? main_q.rd : '0;
  assign out_wen    = main_vld & main_q.wen & (main_q.rd != '0);

  assign skid_hit = skid_vld & skid_q.wen & (skid_q.rd != '0);
  assign main_hit = main_vld & main_q.wen & (main_q.rd != '0);

  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = '0;
    fwd_data  = '0;
    unique case (1'b1)
      skid_hit: begin
        fwd_valid = 1'b1;
        fwd_rd    = skid_q.rd;
        fwd_data  = skid_q.res;
      end
      main_hit && !skid_hit: begin
        fwd_valid = 1'b1;
        fwd_rd    = main_q.rd;
        fwd_data  = main_q.res;
      end
      default: ;
    endcase
  end

`ifdef ALU_EX_WB_STICKY_OV_EN
  logic ov_q, ov_d;

  always_comb begin
    ov_d = ov_q;
    if (take && main_q.fwen && main_q.v) ov_d = 1'b1;
    else if (ov_clr)                     ov_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ov_q <= 1'b0;
    else        ov_q <= ov_d;
  end

  assign ov_sticky = ov_q;
`else
  logic unused_ov_clr;
  assign unused_ov_clr = ov_clr;
  assign ov_sticky     = 1'b0;
`endif

endmodule

// File: doc/alu_ex_wb_stage.md
Name: alu_ex_wb_stage

Overview:
- Registered EX/WB pipeline stage directly downstream of the 128-bit ALU.
- Captures the ALU result, its four flags and writeback control, and buffers them in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Commits flags to an architectural status register in order.
- Exposes a forwarding port so the operand-select logic upstream of the ALU can bypass the register file.

Parameters:
LENGTH, 128, datapath width; must match the ALU width.
RD_W, 5, destination register index width.

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush
in_valid  input  1  ALU result valid
in_ready  output  1  stage can accept
in_result  input  LENGTH  ALU out
in_carry  input  1  ALU carry_flag
in_zero  input  1  ALU zero_flag
in_sign  input  1  ALU sign_flag
in_overflow  input  1  ALU overflow_flag
in_rd  input  RD_W  destination register
in_wen  input  1  register write enable
in_fwen  input  1  flag write enable
out_valid  output  1  writeback entry valid
out_ready  input  1  register file accepts
out_result  output  LENGTH  writeback data
out_rd  output  RD_W  writeback register
out_wen  output  1  writeback enable
status  output  4  committed flags {C,Z,S,V}
fwd_valid  output  1  forwarding hit available
fwd_rd  output  RD_W  forwarded register index
fwd_data  output  LENGTH  forwarded data
ov_clr  input  1  clear sticky overflow (optional feature)
ov_sticky  output  1  sticky overflow (optional feature)

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; entries invalid; status=4'b0000; in_ready=1 on the first clk edge after deassertion.
- Storage: main entry (drives out_*) plus skid entry. Each entry holds {result, C, Z, S, V, rd, wen, fwen}.
- State machine:
  - EMPTY: main and skid invalid.
  - ONE: main valid.
  - FULL: main and skid valid.
- Handshake rules:
  - An input beat is accepted when in_valid & in_ready. An output beat is taken when out_valid & out_ready.
  - in_ready is registered: in_ready = (state != FULL).
  - in_result and the other in_* inputs may change only after acceptance. out_* are held stable while out_valid & ~out_ready.
- Transitions:
  - EMPTY + accept -> ONE. Data enters main, so latency is 1 cycle from input to output.
  - ONE + accept, no take -> FULL. Data enters skid.
  - ONE + accept + take -> ONE. Main is overwritten with new data.
  - ONE + take, no accept -> EMPTY.
  - FULL + take -> ONE. Skid moves to main.
  - FULL + accept cannot occur, because in_ready=0.
- Ordering: strictly FIFO; no reordering.
- Status commit: on an output take with fwen=1, status <= {C,Z,S,V} of that entry. fwen=0 leaves status unchanged. Status is never updated on accept.
- out_wen = main.wen & (main.rd != 0). Register 0 is never written and never forwarded.
- Forwarding:
  - The youngest valid entry with wen=1 and rd!=0 wins: skid if valid, otherwise main.
  - fwd_valid=1, fwd_rd and fwd_data are combinational from that entry.
  - With no hit: fwd_valid=0 and fwd_rd/fwd_data=0.
- Flush (synchronous, highest priority):
  - Next state is EMPTY and entries are invalidated.
  - An input presented in the same cycle is dropped.
  - An output take in the same cycle still commits its flags.
  - status is otherwise untouched.
- Reset mid-operation: immediate return to reset values regardless of state; in-flight entries are lost.
- Width: result is passed through unmodified (no sign or zero extension); LENGTH must equal the ALU LENGTH.

Optional Feature:
- Macro: ALU_EX_WB_STICKY_OV_EN.
- When defined:
  - ov_sticky is set on any output take whose entry has V=1 and fwen=1.
  - Cleared only by ov_clr=1 or reset; set has priority over a same-cycle ov_clr.
  - flush does not clear it.
- When undefined: ov_sticky is tied to 0 and ov_clr is ignored. All other behaviour is identical.

Test Plan:
- Reset and single beat: reset, then accept result=128'h1, rd=3, wen=1, fwen=1, C/Z/S/V=1/0/0/0, out_ready=1 -> out_valid=1 the next cycle with out_result=1, out_rd=3; status=4'b1000 after the take.
- Backpressure: out_ready=0, accept two beats A=0xAA and B=0xBB -> in_ready=0 (FULL); out holds 0xAA; raise out_ready -> 0xAA then 0xBB in order; in_ready=1 one cycle after the first take.
- Forwarding priority: main rd=5 data=0x11, skid rd=5 data=0x22 -> fwd_valid=1, fwd_data=0x22; rd=0 entries only -> fwd_valid=0, out_wen=0.
- Flag gating: take an entry with fwen=0 and Z=1 -> status unchanged; next entry with fwen=1, Z=1 -> status=4'b0100.
- Flush in FULL with simultaneous in_valid and take (main fwen=1, V=1) -> EMPTY next cycle, input dropped, status V=1; with macro, ov_sticky=1 until ov_clr pulse, then 0.
- Async reset asserted mid-cycle in FULL -> all outputs 0 immediately, without waiting for a clk edge.
